vu_level_ctrl: RTL and testbench
================================

# vu_level_ctrl

Level/peak controller between the UART byte path and the VGA bar renderer of the VU meter. It accepts validated sample bytes at any time and keeps the maximum per video frame. Once per frame it computes a ballistic display level (instant attack, linear decay) and a peak-hold marker. It then publishes both as stable registers, so the renderer never sees a mid-frame change.

## Interface
Parameters:
- DATA_W, 8, sample/level width
- DECAY_STEP, 4, level decrement per frame when the input is lower
- PEAK_DECAY, 2, peak decrement per frame after hold expires
- HOLD_FRAMES, 30, frames the peak is held after a new maximum; counter width $clog2(HOLD_FRAMES+1)

Ports (one clock; reset is asynchronous and active-low):
- clock, in, 1, pixel-domain clock
- reset, in, 1, asynchronous active-low reset
- enable, in, 1, global run enable
- data_in, in, DATA_W, sample byte, valid when load=1
- load, in, 1, one-cycle strobe, already synchronous to clock
- error, in, 1, framing error qualifier for the current load
- frame_start, in, 1, one-cycle pulse at start of vertical blanking
- level, out, DATA_W, published display level
- peak, out, DATA_W, published peak marker
- level_valid, out, 1, one-cycle pulse when level/peak update
- frame_overrun, out, 1, sticky: frame_start arrived while FSM busy

## Operation
- Capture: load && !error && enable sets pending=1 and updates frame_max:
  - frame_max <= data_in when pending was 0.
  - frame_max <= max(frame_max, data_in) otherwise.
- Error handling:
  - load && error: sample dropped; no state change.
  - load with enable=0: ignored.
- FSM: IDLE, CALC, PUBLISH.
  - IDLE -> CALC on frame_start && enable.
  - CALC -> PUBLISH unconditionally.
  - PUBLISH -> IDLE unconditionally.
- CALC computes:
  - decayed = level_r - DECAY_STEP, saturating at 0.
  - level_n = pending ? max(frame_max, decayed) : decayed.
  - Clears pending, unless a qualifying load occurs in the same cycle; in that case the load is kept for the next frame.
- Peak (in CALC, from level_n):
  - level_n >= peak_r: peak_n = level_n, hold = HOLD_FRAMES.
  - Else, hold != 0: hold decrements and peak is kept.
  - Else: peak_n = peak_r - PEAK_DECAY, saturating at 0, then floored at level_n.
- PUBLISH: level <= level_n, peak <= peak_n, level_valid=1.
- Arithmetic:
  - All compares are unsigned.
  - Saturating subtraction uses a DATA_W+1 borrow bit.
  - Invariant: peak >= level always.
- frame_start in CALC or PUBLISH: ignored and sets frame_overrun. It is cleared only by reset.
- enable=0: in-flight CALC/PUBLISH completes; afterwards outputs hold.

## Timing
- Reset values: level=0, peak=0, level_valid=0, frame_overrun=0, state=IDLE, pending=0, frame_max=0, hold=0.
- Latency from frame_start:
  - frame_start sampled at edge N.
  - CALC registers at N+1.
  - level/peak change and level_valid is high at edge N+2, for exactly one cycle.
- A load coincident with frame_start (edge N) is included in that frame's CALC.
- A load at edge N+1 (CALC) is carried to the next frame.
- Reset asserted mid-operation: all registers return to reset values immediately; no level_valid is issued.
- Outputs are registered only; no combinational path from inputs to outputs.

## Configuration
- VU_PEAK_HOLD_EN defined: peak hold/decay logic and hold counter are present, as above.
- Undefined: the hold counter and peak logic are removed. peak is driven from the same register as level; HOLD_FRAMES and PEAK_DECAY are unused.

## Structure
- Shared package vu_pkg:
  - state enum (IDLE, CALC, PUBLISH)
  - default DATA_W
  - a saturating-subtract function shared with the renderer's scale logic
- One natural sub-module: vu_peak_hold, containing the hold counter and peak register. It takes level_n and a calc strobe, and returns peak_n. It is instantiated only under VU_PEAK_HOLD_EN.

## Test plan
- Attack: reset, then load 0xC8 and frame_start → level=0xC8, peak=0xC8, level_valid pulses once at N+2.
- Decay: after level=0xC8, 3 frames with no loads → level 0xC4, 0xC0, 0xBC; peak stays 0xC8 (hold=30).
- Peak release: HOLD_FRAMES=2, level 0x80 then no loads → peak 0x80, 0x80, 0x80, then 0x7E, floored at level.
- Frame max: loads 0x10, 0x90 (error=1), 0x40 in one frame → level=0x40; the errored byte is ignored.
- Overrun and boundary:
  - frame_start at N and N+1 → one level_valid, frame_overrun=1.
  - level=0x02 with DECAY_STEP=4 → level=0x00, no wrap.
- Reset mid-CALC: assert reset at N+1 → no level_valid, all outputs 0. The next frame with load 0x20 → level=0x20.

Source files
------------

// File: rtl/vu_pkg.sv
// Shared VU meter definitions: FSM states, default sample width and the
// saturating subtract that the renderer's scale logic also uses.
package vu_pkg;

  localparam int VU_DATA_W = 8;
  localparam int VU_SAT_W  = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALC    = 2'd1,
    PUBLISH = 2'd2
  } vu_state_e;

  // a - b clamped at zero; the extra top bit of the difference is the borrow.
  function automatic logic [VU_SAT_W-1:0] vu_sat_sub(input logic [VU_SAT_W-1:0] a,
                                                     input logic [VU_SAT_W-1:0] b);
    logic [VU_SAT_W:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[VU_SAT_W] ? '0 : diff[VU_SAT_W-1:0];
  endfunction

endpackage

// File: rtl/vu_peak_hold.sv
// Peak-hold marker: holds a new maximum for HOLD_FRAMES frames, then decays
// linearly, never dropping below the level. Present only with VU_PEAK_HOLD_EN.
`ifdef VU_PEAK_HOLD_EN
module vu_peak_hold
  import vu_pkg::*;
#(
  parameter int DATA_W      = VU_DATA_W,
  parameter int PEAK_DECAY  = 2,
  parameter int HOLD_FRAMES = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              calc,
  input  logic [DATA_W-1:0] level_n,
  output logic [DATA_W-1:0] peak_n
);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] peak_q, peak_d, released;

  always_comb begin
    hold_d   = hold_q;
    peak_d   = peak_q;
    released = DATA_W'(vu_sat_sub(VU_SAT_W'(peak_q), VU_SAT_W'(PEAK_DECAY)));
    if (calc) begin
      if (level_n >= peak_q) begin
        peak_d = level_n;
        hold_d = HOLD_W'(HOLD_FRAMES);
      end else if (hold_q != '0) begin
        hold_d = hold_q - HOLD_W'(1);
      end else begin
        peak_d = (released < level_n) ? level_n : released;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      peak_q <= '0;
    end else begin
      hold_q <= hold_d;
      peak_q <= peak_d;
    end
  end

  assign peak_n = peak_q;

endmodule
`endif

// File: rtl/vu_level_ctrl.sv
// VU level/peak controller: per-frame max capture, ballistic level and a
// published peak marker. VU_PEAK_HOLD_EN enables the peak-hold logic.
module vu_level_ctrl
  import vu_pkg::*;
#(
  parameter int DATA_W      = VU_DATA_W,
  parameter int DECAY_STEP  = 4,
  parameter int PEAK_DECAY  = 2,
  parameter int HOLD_FRAMES = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  input  logic              error,
  input  logic              frame_start,
  output logic [DATA_W-1:0] level,
  output logic [DATA_W-1:0] peak,
  output logic              level_valid,
  output logic              frame_overrun
);
  vu_state_e state_q, state_d;
  logic pending_q, pending_d;
  logic [DATA_W-1:0] frame_max_q, frame_max_d;
  logic [DATA_W-1:0] level_n_q, level_n_d;
  logic [DATA_W-1:0] level_q, level_d;
  logic [DATA_W-1:0] decayed, level_n;
  logic valid_q, valid_d, overrun_q, overrun_d;
  logic capture, calc;

  assign capture = load && !error && enable;
  assign calc    = (state_q == CALC);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start && enable) state_d = CALC;
      CALC:    state_d = PUBLISH;
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    decayed     = DATA_W'(vu_sat_sub(VU_SAT_W'(level_q), VU_SAT_W'(DECAY_STEP)));
    level_n     = (pending_q && frame_max_q > decayed) ? frame_max_q : decayed;
    pending_d   = pending_q;
    frame_max_d = frame_max_q;
    // A load landing on the CALC cycle opens the next frame's max.
    if (calc) begin
      pending_d = capture;
      if (capture) frame_max_d = data_in;
    end else if (capture) begin
      pending_d   = 1'b1;
      frame_max_d = (pending_q && frame_max_q > data_in) ? frame_max_q : data_in;
    end
    level_n_d = calc ? level_n : level_n_q;
    overrun_d = overrun_q | (frame_start && state_q != IDLE);
  end

  always_comb begin
    valid_d = (state_q == PUBLISH);
    level_d = valid_d ? level_n_q : level_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q   <= 1'b0;
      frame_max_q <= '0;
      level_n_q   <= '0;
      level_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      frame_max_q <= frame_max_d;
      level_n_q   <= level_n_d;
      level_q     <= level_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef VU_PEAK_HOLD_EN
  logic [DATA_W-1:0] peak_n, peak_q, peak_d;

  vu_peak_hold #(
    .DATA_W     (DATA_W),
    .PEAK_DECAY (PEAK_DECAY),
    .HOLD_FRAMES(HOLD_FRAMES)
  ) u_peak_hold (
    .clock  (clock),
    .reset  (reset),
    .calc   (calc),
    .level_n(level_n),
    .peak_n (peak_n)
  );

  assign peak_d = valid_d ? peak_n : peak_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) peak_q <= '0;
    else        peak_q <= peak_d;
  end

  assign peak = peak_q;
`else
  // Without hold logic the marker simply tracks the level.
  logic unused_cfg;
  assign unused_cfg = ^{HOLD_FRAMES, PEAK_DECAY};
  assign peak       = level_q;
`endif

  assign level         = level_q;
  assign level_valid   = valid_q;
  assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_vu_level_ctrl.sv
// Self-checking bench for vu_level_ctrl: frame-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vu_level_ctrl;
  localparam int DW    = 8;
  localparam int DECAY = 4;
  localparam int PDEC  = 2;
  localparam int HOLD  = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic load = 1'b0;
  logic error = 1'b0;
  logic frame_start = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] level, peak;
  logic level_valid, frame_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase counts edges since an accepted frame_start.
  int m_phase, m_level, m_peak, m_pk_r, m_hold, m_lvl_n, m_peak_n;
  bit m_valid, m_ovr;
  int m_samples[$];

  vu_level_ctrl #(
    .DATA_W     (DW),
    .DECAY_STEP (DECAY),
    .PEAK_DECAY (PDEC),
    .HOLD_FRAMES(HOLD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .data_in      (data_in),
    .load         (load),
    .error        (error),
    .frame_start  (frame_start),
    .level        (level),
    .peak         (peak),
    .level_valid  (level_valid),
    .frame_overrun(frame_overrun)
  );

  always #5 clock = ~clock;

  function automatic int sat(input int a, input int b);
    return (a > b) ? a - b : 0;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_level = 0; m_peak = 0; m_pk_r = 0; m_hold = 0;
    m_lvl_n = 0; m_peak_n = 0; m_valid = 0; m_ovr = 0;
    m_samples.delete();
  endtask

  task automatic model_step(input bit ld, input int d, input bit er, input bit fs, input bit en);
    bit q;
    int ln;
    q = ld && !er && en;
    m_valid = 0;
    if (m_phase == 1) begin
      ln = sat(m_level, DECAY);
      foreach (m_samples[i]) if (m_samples[i] > ln) ln = m_samples[i];
      m_lvl_n = ln;
`ifdef VU_PEAK_HOLD_EN
      if (ln >= m_pk_r) begin
        m_pk_r = ln; m_hold = HOLD;
      end else if (m_hold > 0) begin
        m_hold--;
      end else begin
        m_pk_r = sat(m_pk_r, PDEC);
        if (m_pk_r < ln) m_pk_r = ln;
      end
      m_peak_n = m_pk_r;
`else
      m_peak_n = ln;
`endif
      m_samples.delete();
      if (q) m_samples.push_back(d);
      if (fs) m_ovr = 1;
      m_phase = 2;
    end else if (m_phase == 2) begin
      if (q) m_samples.push_back(d);
      m_level = m_lvl_n;
      m_peak  = m_peak_n;
      m_valid = 1;
      if (fs) m_ovr = 1;
      m_phase = 0;
    end else begin
      if (q) m_samples.push_back(d);
      if (fs && en) m_phase = 1;
    end
  endtask

  task automatic compare_all();
    check("level", int'(level), m_level);
    check("peak", int'(peak), m_peak);
    check("level_valid", int'(level_valid), int'(m_valid));
    check("frame_overrun", int'(frame_overrun), int'(m_ovr));
  endtask

  task automatic step(input bit ld, input int d, input bit er, input bit fs, input bit en);
    load = ld; data_in = DW'(d); error = er; frame_start = fs; enable = en;
    model_step(ld, d, er, fs, en);
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 1);
  endtask

  task automatic frame(input bit ld, input int d);
    step(ld, d, 0, 1, 1);
    idle();
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #2;
    compare_all();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int exp_l[3];
    int exp_p[3];
    int nv;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_level", int'(level), 0);
    check("reset_peak", int'(peak), 0);
    check("reset_valid", int'(level_valid), 0);
    check("reset_overrun", int'(frame_overrun), 0);
    reset = 1'b1;

    // Attack: level jumps straight to the sample, valid only at N+2.
    step(1, 'hC8, 0, 1, 1);
    idle();
    check("attack_valid_n1", int'(level_valid), 0);
    idle();
    check("attack_level", int'(level), 'hC8);
    check("attack_peak", int'(peak), 'hC8);
    check("attack_valid_n2", int'(level_valid), 1);
    idle();
    check("attack_valid_after", int'(level_valid), 0);

    // Linear decay with no new samples.
    exp_l = '{'hC4, 'hC0, 'hBC};
`ifdef VU_PEAK_HOLD_EN
    exp_p = '{'hC8, 'hC8, 'hC6};
`else
    exp_p = '{'hC4, 'hC0, 'hBC};
`endif
    for (int i = 0; i < 3; i++) begin
      frame(0, 0);
      check("decay_level", int'(level), exp_l[i]);
      check("decay_peak", int'(peak), exp_p[i]);
    end

    // Peak release after the hold window, floored at the level.
    do_reset();
    frame(1, 'h80);
    check("release_peak0", int'(peak), 'h80);
    exp_l = '{'h7C, 'h78, 'h74};
`ifdef VU_PEAK_HOLD_EN
    exp_p = '{'h80, 'h80, 'h7E};
`else
    exp_p = '{'h7C, 'h78, 'h74};
`endif
    for (int i = 0; i < 3; i++) begin
      frame(0, 0);
      check("release_level", int'(level), exp_l[i]);
      check("release_peak", int'(peak), exp_p[i]);
    end

    // Frame max ignores errored bytes.
    do_reset();
    step(1, 'h10, 0, 0, 1);
    step(1, 'h90, 1, 0, 1);
    step(1, 'h40, 0, 0, 1);
    frame(0, 0);
    check("framemax_level", int'(level), 'h40);

    // Back-to-back frame_start: one publish, sticky overrun.
    nv = 0;
    step(0, 0, 0, 1, 1); nv += int'(level_valid);
    step(0, 0, 0, 1, 1); nv += int'(level_valid);
    idle();              nv += int'(level_valid);
    idle();              nv += int'(level_valid);
    check("overrun_valid_count", nv, 1);
    check("overrun_flag", int'(frame_overrun), 1);
    check("overrun_level", int'(level), 'h3C);

    // Decay saturates at zero.
    do_reset();
    frame(1, 2);
    check("boundary_level2", int'(level), 2);
    frame(0, 0);
    check("boundary_level0", int'(level), 0);

    // Reset during CALC: no publish, clean restart.
    step(1, 'h55, 0, 1, 1);
    do_reset();
    check("midreset_level", int'(level), 0);
    check("midreset_overrun", int'(frame_overrun), 0);
    nv = 0;
    for (int i = 0; i < 3; i++) begin
      idle();
      nv += int'(level_valid);
    end
    check("midreset_no_valid", nv, 0);
    frame(1, 'h20);
    check("midreset_next_level", int'(level), 'h20);

    // Disable mid-flight: the frame completes, then outputs hold.
    step(0, 0, 0, 1, 1);
    step(1, 'hF0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check("disable_valid", int'(level_valid), 1);
    check("disable_level", int'(level), 'h1C);
    for (int i = 0; i < 4; i++) step(1, 'hFF, 0, 1, 0);
    check("disable_hold", int'(level), 'h1C);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      step($urandom_range(0, 3) == 0, int'($urandom_range(0, 255)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 15) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
